// File: rtl/byte_serial_add_seq_if.sv
// byte_serial_add_seq_if: request/result bundle for the byte-serial add sequencer
interface byte_serial_add_seq_if #(parameter int NBYTES = 4);
  logic start;
  logic [8*NBYTES-1:0] op_a;
  logic [8*NBYTES-1:0] op_b;
  logic cin;
  logic busy;
  logic done;
  logic [8*NBYTES-1:0] result;
  logic cout;
  modport master(output start, op_a, op_b, cin, input busy, done, result, cout);
  modport slave(input start, op_a, op_b, cin, output busy, done, result, cout);
endinterface

// File: rtl/byte_serial_add_seq.sv
// byte_serial_add_seq: wide add performed one byte per cycle through an external 8-bit adder
module byte_serial_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  byte_serial_add_seq_if.slave  bus,
  output logic [7:0]            add_in1,
  output logic [7:0]            add_in2,
  output logic                  add_cin,
  input  logic [7:0]            add_sum,
  input  logic                  add_cout
);
  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state;
  logic [W-1:0]  a_reg, b_reg, result;
  logic          carry_reg, busy, done, cout;
  logic [IW-1:0] idx;
  assign add_in1     = (state == RUN) ? a_reg[8*idx +: 8] : '0;
  assign add_in2     = (state == RUN) ? b_reg[8*idx +: 8] : '0;
  assign add_cin     = (state == RUN) ? carry_reg : 1'b0;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.result  = result;
  assign bus.cout    = cout;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      result    <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cout      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          a_reg     <= bus.op_a;
          b_reg     <= bus.op_b;
          carry_reg <= bus.cin;
          idx       <= '0;
          result    <= '0;
          cout      <= 1'b0;
          busy      <= 1'b1;
          state     <= RUN;
        end
        RUN: begin
          result[8*idx +: 8] <= add_sum;
          carry_reg          <= add_cout;
          if (idx == LAST) begin
            cout  <= add_cout;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_byte_serial_add_seq.sv
// tb_byte_serial_add_seq: directed checks of the byte-serial add sequencer with a behavioural 8-bit adder
module tb_byte_serial_add_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] add_in1, add_in2, add_sum;
  logic add_cin, add_cout;
  int checks = 0;
  int errors = 0;
  byte_serial_add_seq_if #(.NBYTES(4)) bus();
  byte_serial_add_seq #(.NBYTES(4)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .add_in1(add_in1), .add_in2(add_in2), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );
  assign {add_cout, add_sum} = 9'(add_in1) + 9'(add_in2) + 9'(add_cin);
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_idle_regs(input string tag);
    check({tag, " busy"}, bus.busy, 0);
    check({tag, " done"}, bus.done, 0);
    check({tag, " result"}, bus.result, 0);
    check({tag, " cout"}, bus.cout, 0);
    check({tag, " add_bus"}, {add_in1, add_in2, add_cin}, 0);
  endtask
  // start an add, then corrupt (or, with poke, re-request) the inputs while it runs
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic c,
                        input logic [31:0] er, input logic ec, input bit poke);
    logic carry;
    logic [8:0] s;
    bus.start = 1'b1;
    bus.op_a = a;
    bus.op_b = b;
    bus.cin = c;
    step();
    bus.start = poke;
    bus.op_a = poke ? 32'h1 : ~a;
    bus.op_b = poke ? 32'h1 : ~b;
    bus.cin = poke ? 1'b0 : ~c;
    carry = c;
    for (int i = 0; i < 4; i++) begin
      check({tag, " run busy"}, bus.busy, 1);
      check({tag, " run done"}, bus.done, 0);
      check({tag, " add_in1"}, add_in1, a[8*i +: 8]);
      check({tag, " add_in2"}, add_in2, b[8*i +: 8]);
      check({tag, " add_cin"}, add_cin, carry);
      s = 9'(a[8*i +: 8]) + 9'(b[8*i +: 8]) + 9'(carry);
      carry = s[8];
      step();
    end
    check({tag, " done"}, bus.done, 1);
    check({tag, " done busy"}, bus.busy, 1);
    check({tag, " result"}, bus.result, er);
    check({tag, " cout"}, bus.cout, ec);
    check({tag, " done add_bus"}, {add_in1, add_in2, add_cin}, 0);
    step();
    bus.start = 1'b0;
    check({tag, " after done"}, bus.done, 0);
    check({tag, " after busy"}, bus.busy, 0);
    check({tag, " held result"}, bus.result, er);
    check({tag, " held cout"}, bus.cout, ec);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.cin = 1'b0;
    step();
    step();
    check_idle_regs("reset");
    rst = 1'b0;
    step();
    check_idle_regs("idle");
    run_op("t1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    run_op("t2", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    run_op("t3", 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0);
    run_op("t4a", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    step();
    check("t4 ignored busy", bus.busy, 0);
    check("t4 ignored result", {bus.cout, bus.result}, {1'b1, 32'h0});
    run_op("t4b", 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
    bus.start = 1'b1;
    bus.op_a = 32'h1111_1111;
    bus.op_b = 32'h1111_1111;
    bus.cin = 1'b0;
    step();
    bus.start = 1'b0;
    step();
    check("t5 partial result", bus.result, 32'h0000_0022);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle_regs("t5 abort");
    for (int i = 0; i < 6; i++) begin
      check("t5 no done", bus.done, 0);
      step();
    end
    run_op("t6", 32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 32'hDFD1_0457, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
